md_scheduler: RTL and testbench

//  Sequences the HI/LO multiply/divide resource of the pipelined MIPS core.

---
 rtl/md_pkg.sv | 42 ++++
 rtl/md_scheduler_if.sv | 29 ++
 rtl/md_datapath.sv | 62 ++++++
 rtl/md_scheduler.sv | 126 ++++++++++++
 tb/tb_md_scheduler.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// ============================================================================
// md_pkg : MD op encodings, default latencies and decode helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package md_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  localparam int MD_DEF_MUL_LAT = 5;
  localparam int MD_DEF_DIV_LAT = 10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // Encodings above MD_MTLO are illegal and behave exactly like MD_NONE.
  function automatic logic is_md_op(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_MTLO);
  endfunction

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_scheduler_if.sv
// ============================================================================
// md_scheduler_if : EX-stage <-> HI/LO scheduler signal bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface md_scheduler_if;
  logic        op_valid;
  logic [3:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        stall_req;
  logic [31:0] mf_data;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output op_valid, op, rs_val, rt_val,
    input  busy, stall_req, mf_data, hi, lo
  );

  modport slave (
    input  op_valid, op, rs_val, rt_val,
    output busy, stall_req, mf_data, hi, lo
  );
endinterface

`default_nettype wire

// File: rtl/md_datapath.sv
// ============================================================================
// md_datapath : combinational 32x32 multiply and divide for the HI/LO unit
// Rev 1.0
// ============================================================================
`default_nettype none

module md_datapath
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic [63:0] w_sprod;
  logic [63:0] w_uprod;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_safe_b;
  logic [31:0] w_quo_mag;
  logic [31:0] w_rem_mag;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  always_comb begin
    w_sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    w_uprod = {32'd0, a} * {32'd0, b};

    // Signed divide runs on magnitudes; 0x80000000/-1 falls out as 0x80000000 rem 0.
    w_neg_a   = (op == MD_DIV) && a[31];
    w_neg_b   = (op == MD_DIV) && b[31];
    w_mag_a   = w_neg_a ? (~a + 32'd1) : a;
    w_mag_b   = w_neg_b ? (~b + 32'd1) : b;
    w_safe_b  = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
    w_quo_mag = w_mag_a / w_safe_b;
    w_rem_mag = w_mag_a % w_safe_b;
    w_quo     = (w_neg_a ^ w_neg_b) ? (~w_quo_mag + 32'd1) : w_quo_mag;
    w_rem     = w_neg_a ? (~w_rem_mag + 32'd1) : w_rem_mag;

    div_zero = is_div(op) && (b == 32'd0);

    res_hi = '0;
    res_lo = '0;
    case (op)
      MD_MULT:          {res_hi, res_lo} = w_sprod;
      MD_MULTU:         {res_hi, res_lo} = w_uprod;
      MD_DIV, MD_DIVU: begin
        res_hi = w_rem;
        res_lo = w_quo;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/md_scheduler.sv
// ============================================================================
// md_scheduler : HI/LO multiply/divide sequencer with fixed latency and stall
// Rev 1.0
// ============================================================================
`default_nettype none

module md_scheduler
  import md_pkg::*;
#(
  parameter int MUL_LAT = MD_DEF_MUL_LAT,
  parameter int DIV_LAT = MD_DEF_DIV_LAT
) (
  input  logic           clk,
  input  logic           reset,
  md_scheduler_if.slave  bus
);

  localparam logic [3:0] c_mul_cnt = 4'(MUL_LAT);
  localparam logic [3:0] c_div_cnt = 4'(DIV_LAT);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;

  logic        w_accept;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_div_zero;
  logic [31:0] w_mf_data;

  md_datapath u_datapath (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .res_hi   (w_res_hi),
    .res_lo   (w_res_lo),
    .div_zero (w_div_zero)
  );

  always_comb begin
    w_accept = bus.op_valid && is_md_op(bus.op) && (state_q == ST_IDLE);
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          if (is_muldiv(bus.op)) begin
            op_d    = bus.op;
            a_d     = bus.rs_val;
            b_d     = bus.rt_val;
            cnt_d   = is_div(bus.op) ? c_div_cnt : c_mul_cnt;
            state_d = ST_BUSY;
          end else if (bus.op == MD_MTHI) begin
            hi_d = bus.rs_val;
          end else if (bus.op == MD_MTLO) begin
            lo_d = bus.rs_val;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_IDLE;
          // A zero divisor still burns the full latency but leaves HI/LO alone.
          if (!w_div_zero) begin
            hi_d = w_res_hi;
            lo_d = w_res_lo;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_BUSY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    w_mf_data = '0;
    if (bus.op_valid) begin
      if (bus.op == MD_MFHI)      w_mf_data = hi_q;
      else if (bus.op == MD_MFLO) w_mf_data = lo_q;
    end
  end

  assign bus.stall_req = !reset && bus.op_valid && is_md_op(bus.op) && (state_q == ST_BUSY);
  assign bus.mf_data   = w_mf_data;
  assign bus.busy      = busy_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_md_scheduler.sv
// ============================================================================
// tb_md_scheduler : scoreboard bench for the HI/LO multiply/divide scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_md_scheduler;
  import md_pkg::*;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  logic clk;
  logic reset;
  md_scheduler_if bus ();

  md_scheduler #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_miss = 0;
  int          last_stall = 0;
  int          busy_cycles = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic done in 64-bit integers, independent of the RTL datapath.
  function automatic logic [63:0] ref_md(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] hi,
                                         input logic [31:0] lo);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic   [63:0]   res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = {hi, lo};
    case (op)
      MD_MULT:  res = sa * sb;
      MD_MULTU: res = ua * ub;
      MD_DIV:   if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      MD_DIVU:  if (b != 0) begin
        res = {ua % ub, 32'd0} | (ua / ub);
      end
      default: ;
    endcase
    return res;
  endfunction

  // Scoreboard: on every falling edge of busy, pop one expectation and compare.
  initial begin
    logic prev;
    int   run;
    exp_t e;
    prev = 1'b0;
    run  = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b0;
        run  = 0;
      end else begin
        if (bus.busy) begin
          run++;
          busy_cycles++;
        end else if (prev) begin
          check("sb_depth", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("commit_hi", bus.hi, e.hi);
            check("commit_lo", bus.lo, e.lo);
            check("busy_len", run, e.lat);
          end
          run = 0;
        end
        prev = bus.busy;
      end
    end
  end

  // Present an op, hold it while stalled, then let one edge accept it.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int          n;
    logic [63:0] r;
    n = 0;
    bus.op_valid = 1'b1;
    bus.op       = op;
    bus.rs_val   = a;
    bus.rt_val   = b;
    #1;
    while (bus.stall_req && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 40) check("stall_bound", n, 0);
    last_stall = n;
    if (op == MD_MFHI) check("mfhi_data", bus.mf_data, m_hi);
    if (op == MD_MFLO) check("mflo_data", bus.mf_data, m_lo);
    if (is_muldiv(op)) begin
      r = ref_md(op, a, b, m_hi, m_lo);
      exp_q.push_back('{hi: r[63:32], lo: r[31:0], lat: is_div(op) ? DIV_LAT : MUL_LAT});
      m_hi = r[63:32];
      m_lo = r[31:0];
    end else if (op == MD_MTHI) begin
      m_hi = a;
    end else if (op == MD_MTLO) begin
      m_lo = a;
    end
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    bus.op       = MD_NONE;
    bus.rs_val   = $urandom;
    bus.rt_val   = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 40) check("idle_bound", n, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] rop;
    logic [31:0] ra, rb;

    reset        = 1'b1;
    bus.op_valid = 1'b1;
    bus.op       = MD_MFHI;
    bus.rs_val   = 32'hDEAD_BEEF;
    bus.rt_val   = 32'h1;
    #2;
    check("rst_busy", bus.busy, 0);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_stall", bus.stall_req, 0);
    check("rst_mf", bus.mf_data, 0);
    bus.op_valid = 1'b0;
    bus.op       = MD_NONE;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // MULT / MULTU with a negative operand
    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    check("mult_busy_on", bus.busy, 1);
    wait_idle();
    check("mult_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    issue(MD_MULTU, 32'hFFFF_FFFE, 32'd3);
    wait_idle();
    check("multu_hilo", {bus.hi, bus.lo}, 64'h0000_0002_FFFF_FFFA);

    // DIV signed, then DIVU by zero leaves HI/LO unchanged
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    check("div_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(MD_DIVU, 32'd7, 32'd0);
    wait_idle();
    check("divu_zero_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    // Signed overflow case
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    check("div_ovf_hilo", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

    // MFLO held behind a MULT stalls for the full latency
    issue(MD_MULT, 32'h0001_0000, 32'h0003_0001);
    issue(MD_MFLO, 32'd0, 32'd0);
    check("mflo_stall_cycles", last_stall, MUL_LAT);

    // MTHI then MFHI on the next cycle
    issue(MD_MTHI, 32'h0000_1234, 32'd0);
    check("mthi_stall", last_stall, 0);
    issue(MD_MFHI, 32'd0, 32'd0);
    check("mfhi_stall", last_stall, 0);
    check("mfhi_val", bus.hi, 32'h0000_1234);
    issue(MD_MTLO, 32'hCAFE_0001, 32'd0);
    check("mtlo_val", bus.lo, 32'hCAFE_0001);

    // Back-to-back MULT then DIV
    wait_idle();
    busy_cycles = 0;
    issue(MD_MULT, 32'd12345, 32'hFFFF_FF00);
    issue(MD_DIV, 32'd1000, 32'hFFFF_FFF9);
    check("b2b_div_stall", last_stall, MUL_LAT);
    wait_idle();
    check("b2b_busy_total", busy_cycles, MUL_LAT + DIV_LAT);

    // Illegal encoding: never stalls, never starts an operation
    issue(MD_MULTU, 32'h7, 32'h9);
    bus.op_valid = 1'b1;
    bus.op       = 4'hC;
    #1;
    check("illegal_no_stall", bus.stall_req, 0);
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    check("illegal_not_accepted", bus.busy, 0);
    bus.op_valid = 1'b0;
    bus.op       = MD_NONE;

    // Random mult/div traffic
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(3))
        0: rop = MD_MULT;
        1: rop = MD_MULTU;
        2: rop = MD_DIV;
        default: rop = MD_DIVU;
      endcase
      ra = $urandom;
      rb = ($urandom_range(5) == 0) ? 32'd0 : ($urandom >> $urandom_range(28));
      issue(rop, ra, rb);
      wait_idle();
    end

    // Reset in the third busy cycle of a DIV aborts it
    issue(MD_DIV, 32'd100, 32'd7);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    exp_q.delete();
    m_hi = '0;
    m_lo = '0;
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    bus.op_valid = 1'b1;
    bus.op       = MD_MULT;
    #1;
    check("abort_stall", bus.stall_req, 0);
    bus.op_valid = 1'b0;
    bus.op       = MD_NONE;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (DIV_LAT + 3) @(posedge clk);
    #1;
    check("abort_no_commit", {bus.hi, bus.lo}, 64'd0);
    check("abort_idle", bus.busy, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
